// File: rtl/JZJCoreFTypes.sv
// Shared core types: instruction address select and
// the instruction sequencer state encoding.
package JZJCoreFTypes;

    typedef enum logic {
        NEXT_PC    = 1'b0,
        CURRENT_PC = 1'b1
    } InstructionAddressSource_t;

    typedef enum logic [1:0] {
        INITIAL_FETCH = 2'd0,
        EXECUTE       = 2'd1,
        MEM_WAIT      = 2'd2,
        HALTED        = 2'd3
    } SequencerState_t;

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter.
// Wraps modulo 2^32; cleared by asynchronous reset.
module retire_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        increment,
    output logic [31:0] instret
);

    // count one retirement per enabled edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            instret <= 32'd0;
        else if (increment)
            instret <= instret + 32'd1;
    end

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: steers the fetch address mux, gates
// PC/rd writes, stretches loads/stores and handles halt/resume.
module core_sequencer
    import JZJCoreFTypes::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_access_request,
    input  logic                      halt_request,
    input  logic                      resume,
    output InstructionAddressSource_t instruction_address_source,
    output logic                      pc_write_enable,
    output logic                      rd_write_enable,
    output logic                      data_port_enable,
    output logic                      halted,
    output logic [31:0]               instret
);

    localparam logic [3:0] LoadCount = 4'(MEM_LATENCY - 1);

    SequencerState_t state;
    logic [3:0]      waitCount;
    logic            retire;

    // state and memory wait countdown
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INITIAL_FETCH;
            waitCount <= 4'd0;
        end else begin
            case (state)
                INITIAL_FETCH: state <= EXECUTE;
                EXECUTE: begin
                    if (halt_request)
                        state <= HALTED;
                    else if (mem_access_request) begin
                        waitCount <= LoadCount;
                        state     <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (waitCount != 4'd0)
                        waitCount <= waitCount - 4'd1;
                    else
                        state <= EXECUTE;
                end
                HALTED: begin
                    if (resume)
                        state <= EXECUTE;
                end
                default: state <= INITIAL_FETCH;
            endcase
        end
    end

    // Mealy output decode from state and live inputs
    always_comb begin
        instruction_address_source = CURRENT_PC;
        pc_write_enable            = 1'b0;
        rd_write_enable            = 1'b0;
        data_port_enable           = 1'b0;
        halted                     = 1'b0;
        retire                     = 1'b0;
        case (state)
            EXECUTE: begin
                if (halt_request) begin
                    instruction_address_source = CURRENT_PC;
                end else if (mem_access_request) begin
                    data_port_enable = 1'b1;
                end else begin
                    instruction_address_source = NEXT_PC;
                    pc_write_enable            = 1'b1;
                    rd_write_enable            = 1'b1;
                    retire                     = 1'b1;
                end
            end
            MEM_WAIT: begin
                data_port_enable = 1'b1;
                if (waitCount == 4'd0) begin
                    instruction_address_source = NEXT_PC;
                    pc_write_enable            = 1'b1;
                    rd_write_enable            = 1'b1;
                    retire                     = 1'b1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    // step past the halting instruction, no rd commit
                    instruction_address_source = NEXT_PC;
                    pc_write_enable            = 1'b1;
                    retire                     = 1'b1;
                end
            end
            default: begin
                instruction_address_source = CURRENT_PC;
            end
        endcase
    end

    retire_counter retireCounter (
        .clock     (clock),
        .reset     (reset),
        .increment (retire),
        .instret   (instret)
    );

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed vector table,
// corner sequences, then random stimulus against a reference model.
module tb_core_sequencer;
    import JZJCoreFTypes::*;

    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic memReq = 1'b0;
    logic haltReq = 1'b0;
    logic resume = 1'b0;
    InstructionAddressSource_t src;
    logic pcWe, rdWe, dpe, halted;
    logic [31:0] instret;

    int passed = 0;
    int total = 0;

    always #5 clock = ~clock;

    core_sequencer #(.MEM_LATENCY(LAT)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .mem_access_request         (memReq),
        .halt_request               (haltReq),
        .resume                     (resume),
        .instruction_address_source (src),
        .pc_write_enable            (pcWe),
        .rd_write_enable            (rdWe),
        .data_port_enable           (dpe),
        .halted                     (halted),
        .instret                    (instret)
    );

    typedef struct {
        logic        mem;
        logic        halt;
        logic        res;
        logic        src;
        logic        pcwe;
        logic        rdwe;
        logic        dpe;
        logic        hlt;
        logic [31:0] ir;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chkAll(input string tag, input logic eSrc,
                          input logic ePc, input logic eRd,
                          input logic eDp, input logic eH,
                          input logic [31:0] eIr);
        chk({tag, ".src"}, 32'(src), 32'(eSrc));
        chk({tag, ".pcwe"}, 32'(pcWe), 32'(ePc));
        chk({tag, ".rdwe"}, 32'(rdWe), 32'(eRd));
        chk({tag, ".dpe"}, 32'(dpe), 32'(eDp));
        chk({tag, ".halted"}, 32'(halted), 32'(eH));
        chk({tag, ".instret"}, instret, eIr);
    endtask

    // reference model, instruction-level view
    bit          mStarted;
    bit          mHalted;
    int          mMemLeft;
    logic [31:0] mInstret;

    task automatic modelReset();
        mStarted = 0;
        mHalted  = 0;
        mMemLeft = 0;
        mInstret = 0;
    endtask

    // drive at negedge, compare 1ns later, advance model
    task automatic modelCycle(input logic m, input logic h,
                              input logic r, input string tag);
        logic eSrc, ePc, eRd, eDp, eH;
        memReq = m; haltReq = h; resume = r;
        #1;
        eSrc = 1; ePc = 0; eRd = 0; eDp = 0; eH = 0;
        if (!mStarted) begin
            mStarted = 1;
        end else if (mHalted) begin
            eH = 1;
            if (r) begin
                eSrc = 0; ePc = 1;
                mHalted = 0;
            end
        end else if (mMemLeft > 0) begin
            eDp = 1;
            if (mMemLeft == 1) begin
                eSrc = 0; ePc = 1; eRd = 1;
            end
            mMemLeft--;
        end else if (h) begin
            mHalted = 1;
        end else if (m) begin
            eDp = 1;
            mMemLeft = LAT;
        end else begin
            eSrc = 0; ePc = 1; eRd = 1;
        end
        chkAll(tag, eSrc, ePc, eRd, eDp, eH, mInstret);
        if (ePc) mInstret = mInstret + 32'd1;
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        memReq = 0; haltReq = 0; resume = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelReset();
    endtask

    localparam logic C = 1'b1;
    localparam logic N = 1'b0;

    initial begin
        tbl[0]  = '{0, 0, 0, C, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, N, 1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, N, 1, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, N, 1, 1, 0, 0, 2};
        tbl[4]  = '{1, 0, 0, C, 0, 0, 1, 0, 3};
        tbl[5]  = '{0, 1, 0, C, 0, 0, 1, 0, 3};
        tbl[6]  = '{1, 0, 0, C, 0, 0, 1, 0, 3};
        tbl[7]  = '{0, 0, 0, N, 1, 1, 1, 0, 3};
        tbl[8]  = '{0, 0, 1, N, 1, 1, 0, 0, 4};
        tbl[9]  = '{1, 1, 0, C, 0, 0, 0, 0, 5};
        tbl[10] = '{1, 0, 0, C, 0, 0, 0, 1, 5};
        tbl[11] = '{0, 1, 0, C, 0, 0, 0, 1, 5};
        tbl[12] = '{0, 0, 0, C, 0, 0, 0, 1, 5};
        tbl[13] = '{1, 1, 0, C, 0, 0, 0, 1, 5};
        tbl[14] = '{0, 0, 0, C, 0, 0, 0, 1, 5};
        tbl[15] = '{0, 0, 1, N, 1, 0, 0, 1, 5};
        tbl[16] = '{0, 0, 0, N, 1, 1, 0, 0, 6};
        tbl[17] = '{0, 0, 0, N, 1, 1, 0, 0, 7};

        // reset state while reset is held
        #1;
        chkAll("rst", C, 0, 0, 0, 0, 0);
        doReset();

        // directed table
        for (int i = 0; i < 18; i++) begin
            memReq = tbl[i].mem;
            haltReq = tbl[i].halt;
            resume = tbl[i].res;
            #1;
            chkAll($sformatf("vec%0d", i), tbl[i].src, tbl[i].pcwe,
                   tbl[i].rdwe, tbl[i].dpe, tbl[i].hlt, tbl[i].ir);
            @(negedge clock);
        end
        chk("post.instret", instret, 32'd8);

        // instret wrap
        force dut.retireCounter.instret = 32'hFFFF_FFFF;
        #1;
        release dut.retireCounter.instret;
        memReq = 0; haltReq = 0; resume = 0;
        #1;
        chk("wrap.pre", instret, 32'hFFFF_FFFF);
        chk("wrap.pcwe", 32'(pcWe), 32'd1);
        @(negedge clock);
        chk("wrap.post", instret, 32'd0);

        // async reset in MEM_WAIT with one wait cycle left
        doReset();
        modelCycle(0, 0, 0, "ar.if");
        modelCycle(0, 0, 0, "ar.alu");
        modelCycle(1, 0, 0, "ar.ld");
        modelCycle(0, 0, 0, "ar.w2");
        #1;
        chk("ar.w1.dpe", 32'(dpe), 32'd1);
        chk("ar.w1.src", 32'(src), 32'(C));
        #1;
        reset = 1'b1;
        #1;
        chkAll("ar.async", C, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        chkAll("ar.hold", C, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        modelReset();
        modelCycle(0, 0, 0, "ar.if2");
        modelCycle(0, 0, 0, "ar.alu2");

        // random stimulus vs model
        doReset();
        for (int i = 0; i < 1500; i++) begin
            logic m, h, r;
            m = ($urandom_range(0, 99) < 25);
            h = ($urandom_range(0, 99) < 6);
            r = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                modelCycle(m, h, r, $sformatf("rnd%0d", i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Control FSM that sequences every instruction of the single-issue core. It drives the select of the instruction address mux, either NEXT_PC (prefetch the following instruction) or CURRENT_PC (hold or refetch the current one). It also gates ProgramCounter and register-file writes, stretches load/store instructions over a fixed data-memory latency, supports halt/resume, and keeps a 32-bit retired-instruction counter.

Parameters:
MEM_LATENCY, 1, data-port cycles a load/store occupies after its EXECUTE cycle; legal range 1..15.

Ports:
clock  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_access_request  input  1  decoded instruction is a load or store
halt_request  input  1  decoded instruction is ECALL, EBREAK or illegal
resume  input  1  external pulse; leaves HALTED
instruction_address_source  output  InstructionAddressSource_t  select for instruction address mux
pc_write_enable  output  1  ProgramCounter latches its input this edge
rd_write_enable  output  1  register file commits rd this edge
data_port_enable  output  1  memory controller data port active
halted  output  1  core halted
instret  output  32  retired-instruction count

Behaviour:
- Clock and reset: one clock, clock. reset is asynchronous and active-high.
- States: INITIAL_FETCH, EXECUTE, MEM_WAIT, HALTED. Registered state: state, wait_count[3:0], instret.
- Outputs are combinational from state and inputs (Mealy). Registers update on the rising edge of clock.
- While reset is high:
  - state=INITIAL_FETCH, wait_count=0, instret=0.
  - Outputs: source=CURRENT_PC, pc_write_enable=0, rd_write_enable=0, data_port_enable=0, halted=0.
- INITIAL_FETCH:
  - source=CURRENT_PC (fetch at the reset vector); all enables 0.
  - Always goes to EXECUTE next cycle.
- EXECUTE, priority halt_request > mem_access_request > normal:
  - halt_request=1: source=CURRENT_PC, all enables 0, next state HALTED.
  - mem_access_request=1: source=CURRENT_PC, data_port_enable=1, pc_write_enable=0, rd_write_enable=0. Load wait_count=MEM_LATENCY-1, next state MEM_WAIT.
  - Otherwise: source=NEXT_PC, pc_write_enable=1, rd_write_enable=1, instret+=1, stay in EXECUTE.
- MEM_WAIT:
  - data_port_enable=1.
  - wait_count!=0: source=CURRENT_PC, no writes, wait_count-=1.
  - wait_count==0: source=NEXT_PC, pc_write_enable=1, rd_write_enable=1, instret+=1, next state EXECUTE.
  - halt_request and mem_access_request are ignored in this state.
- HALTED:
  - halted=1, source=CURRENT_PC, all enables 0.
  - resume=1: source=NEXT_PC, pc_write_enable=1 (step past the halting instruction), rd_write_enable=0, instret+=1, next state EXECUTE. halted stays 1 during the resume cycle.
- Latency: non-memory instruction = 1 cycle. Load/store = 1+MEM_LATENCY cycles. Exactly one pc_write_enable pulse per retired instruction.
- instret wraps from 0xFFFFFFFF to 0x00000000.
- Reset mid-MEM_WAIT or mid-HALTED: immediate return to INITIAL_FETCH. No commit; the pending data access is abandoned (data_port_enable drops asynchronously).
- Illegal state encoding: recover to INITIAL_FETCH. Outputs in that state are don't-care.
- Inputs other than resume are sampled only in EXECUTE. resume is sampled only in HALTED.

Decomposition:
- JZJCoreFTypes package:
  - Reuse the existing InstructionAddressSource_t.
  - Add SequencerState_t enum {INITIAL_FETCH, EXECUTE, MEM_WAIT, HALTED}.
- One sub-module: retire_counter. 32-bit counter with async active-high reset and increment enable, output instret; instantiated once.
- The FSM and wait counter stay in core_sequencer.

Test Plan:
- Reset, then 3 ALU instructions (mem_access_request=0, halt_request=0) -> cycle 0 source=CURRENT_PC with no enables; cycles 1-3 source=NEXT_PC, pc_write_enable=1, rd_write_enable=1; instret=3.
- MEM_LATENCY=3, one load in EXECUTE -> data_port_enable=1 for 4 cycles, source=CURRENT_PC for the first 3, single commit on the 4th; instret+1 only; return to EXECUTE.
- halt_request and mem_access_request both 1 in EXECUTE -> HALTED, data_port_enable never asserts. halted=1 for 5 cycles; resume pulse -> one pc_write_enable, rd_write_enable=0, instret+1, back in EXECUTE.
- reset asserted asynchronously in MEM_WAIT with wait_count=1 -> outputs go to reset values before the next edge; no commit; INITIAL_FETCH after release; instret=0.
- instret preset via 0xFFFFFFFF retirements (forced) plus one more ALU instruction -> instret=0x00000000.
- resume asserted in EXECUTE and halt_request asserted in MEM_WAIT -> both ignored; normal sequencing unchanged.
